rob_wb_arbiter: RTL

//  Shares the single ROB writeback port among the ALU, MEM and MUL completion streams.

---
 rtl/rob_wb_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter: one-entry holding regs per ALU/MEM/MUL stream, round-robin onto the single ROB writeback port
module rob_wb_arbiter #(
   parameter int WORD_SIZE       = 32,
   parameter int ROB_ENTRY_WIDTH = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       alu_valid,
   input  logic                       mem_valid,
   input  logic                       mul_valid,
   output logic                       alu_ready,
   output logic                       mem_ready,
   output logic                       mul_ready,
   input  logic [WORD_SIZE-1:0]       alu_data,
   input  logic [WORD_SIZE-1:0]       mem_data,
   input  logic [WORD_SIZE-1:0]       mul_data,
   input  logic [ROB_ENTRY_WIDTH-1:0] alu_rob_id,
   input  logic [ROB_ENTRY_WIDTH-1:0] mem_rob_id,
   input  logic [ROB_ENTRY_WIDTH-1:0] mul_rob_id,
   output logic                       wb_valid,
   output logic [WORD_SIZE-1:0]       wb_data,
   output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
   output logic                       alu_wb_bypass_enable,
   output logic                       mem_wb_bypass_enable,
   output logic                       mul_wb_bypass_enable
);
   logic [2:0]                 r_held;
   logic [WORD_SIZE-1:0]       r_data [3];
   logic [ROB_ENTRY_WIDTH-1:0] r_id   [3];
   logic [1:0]                 r_rr_ptr;
   logic [2:0]                 w_valid, w_ready, w_grant;
   logic [WORD_SIZE-1:0]       w_din  [3];
   logic [ROB_ENTRY_WIDTH-1:0] w_idin [3];
   logic [1:0]                 w_p1, w_p2, w_g;
   logic                       w_any, w_wb;

   // round-robin search from rr_ptr; grant frees the slot so ready can re-accept the same cycle
   always_comb begin
      w_valid   = {mul_valid, mem_valid, alu_valid};
      w_din[0]  = alu_data;
      w_din[1]  = mem_data;
      w_din[2]  = mul_data;
      w_idin[0] = alu_rob_id;
      w_idin[1] = mem_rob_id;
      w_idin[2] = mul_rob_id;
      w_p1      = (r_rr_ptr == 2'd2) ? 2'd0 : r_rr_ptr + 2'd1;
      w_p2      = (w_p1 == 2'd2) ? 2'd0 : w_p1 + 2'd1;
      w_any     = |r_held;
      w_g       = r_held[r_rr_ptr] ? r_rr_ptr : r_held[w_p1] ? w_p1 : w_p2;
      w_grant   = w_any ? (3'b001 << w_g) : 3'b000;
      w_ready   = ~r_held | w_grant;
      w_wb      = w_any & ~flush;
   end

   assign alu_ready            = w_ready[0];
   assign mem_ready            = w_ready[1];
   assign mul_ready            = w_ready[2];
   assign wb_valid             = w_wb;
   assign wb_data              = w_wb ? r_data[w_g] : '0;
   assign wb_rob_id            = w_wb ? r_id[w_g] : '0;
   assign alu_wb_bypass_enable = w_wb & w_grant[0];
   assign mem_wb_bypass_enable = w_wb & w_grant[1];
   assign mul_wb_bypass_enable = w_wb & w_grant[2];

   // holding regs and pointer; flush drops everything including same-cycle accepts
   always_ff @(posedge clk) begin
      if (rst) begin
         r_held   <= '0;
         r_rr_ptr <= '0;
         for (int i = 0; i < 3; i++) begin
            r_data[i] <= '0;
            r_id[i]   <= '0;
         end
      end else if (flush) begin
         r_held   <= '0;
         r_rr_ptr <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (w_valid[i] && w_ready[i]) begin
               r_held[i] <= 1'b1;
               r_data[i] <= w_din[i];
               r_id[i]   <= w_idin[i];
            end else if (w_grant[i]) begin
               r_held[i] <= 1'b0;
            end
         end
         if (w_any) r_rr_ptr <= (w_g == 2'd2) ? 2'd0 : w_g + 2'd1;
      end
   end
endmodule
